// File: rtl/esp32_stream_scheduler_pkg.sv
// Shared definitions for the ESP32 stream scheduler.
//   TAG_W / PAYLOAD_W  : field widths of one 32-bit stream word
//   TAG_HEARTBEAT      : tag reserved for heartbeat words
//   stream_word_t      : packed {tag, payload} word as written to the FIFO
//   make_word          : packs a tag and payload into a stream_word_t
package esp32_stream_pkg;

  localparam int TAG_W     = 4;
  localparam int PAYLOAD_W = 28;
  localparam int WORD_W    = TAG_W + PAYLOAD_W;

  localparam logic [TAG_W-1:0] TAG_HEARTBEAT = 4'hF;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } stream_word_t;

  function automatic stream_word_t make_word(input logic [TAG_W-1:0] tag,
                                             input logic [PAYLOAD_W-1:0] payload);
    stream_word_t w;
    w.tag     = tag;
    w.payload = payload;
    return w;
  endfunction

endpackage

// File: rtl/esp32_stream_scheduler_if.sv
// Producer handshake plus FIFO write port of the stream scheduler.
//   src_valid/src_data/src_ready : NUM_SRC producers, payload i at [28*i +: 28]
//   fifo_almost_full/fifo_full   : FIFO status
//   fifo_wr_en/fifo_data         : FIFO write port
// master = the scheduler, slave = producers plus FIFO.
interface esp32_stream_scheduler_if #(
  parameter int NUM_SRC = 3
);

  logic [NUM_SRC-1:0]                            src_valid;
  logic [NUM_SRC*esp32_stream_pkg::PAYLOAD_W-1:0] src_data;
  logic [NUM_SRC-1:0]                            src_ready;
  logic                                          fifo_almost_full;
  logic                                          fifo_full;
  logic                                          fifo_wr_en;
  logic [esp32_stream_pkg::WORD_W-1:0]           fifo_data;

  modport master (
    input  src_valid, src_data, fifo_almost_full, fifo_full,
    output src_ready, fifo_wr_en, fifo_data
  );

  modport slave (
    output src_valid, src_data, fifo_almost_full, fifo_full,
    input  src_ready, fifo_wr_en, fifo_data
  );

endinterface

// File: rtl/esp32_stream_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (modulo N) wins.
//   req     : request vector
//   ptr     : search start index (kept by the parent)
//   gnt     : one-hot grant, all zero when nothing requests
//   gnt_idx : index of the winner (0 when nothing requests)
//   any     : at least one request present
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Rotating search from ptr; the first hit latches the index, later hits are ignored.
  always_comb begin
    int j;
    j       = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      j       = (int'(ptr) + k) % N;
      gnt_idx = (!any && req[j]) ? IDX_W'(j) : gnt_idx;
      any     = any | req[j];
    end
    gnt = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/esp32_stream_scheduler.sv
// Multi-source scheduler in front of the ESP32 stream FIFO write port.
// Round-robin arbitration of NUM_SRC producers, source-tagged words, lossy
// drop counting under backpressure and a periodic heartbeat word.
//   clk, rst_n   : clock, async active-low reset
//   enable       : low = no grants, no drops, heartbeat timer frozen
//   bus          : producer handshake + FIFO write port (master side)
//   drop_count   : saturating count of discarded lossy words
//   overflow_err : sticky, a write was issued while the FIFO was full
module esp32_stream_scheduler
  import esp32_stream_pkg::*;
#(
  parameter int                 NUM_SRC    = 3,
  parameter logic [NUM_SRC-1:0] LOSSY_MASK = 3'b001,
  parameter int                 HB_PERIOD  = 54000,
  parameter int                 DROP_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  esp32_stream_scheduler_if.master  bus,
  output logic [DROP_W-1:0]         drop_count,
  output logic                      overflow_err
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [DROP_W+4:0] DROP_MAX = {5'b0_0000, {DROP_W{1'b1}}};

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [31:0]        hb_cnt_r;
  logic               hb_pend_r;
  logic [11:0]        hb_seq_r;
  logic               fifo_wr_en_r;
  stream_word_t       fifo_data_r;
  logic [DROP_W-1:0]  drop_count_r;
  logic               overflow_err_r;

  logic [NUM_SRC-1:0] arb_gnt_s;
  logic [PTR_W-1:0]   arb_idx_s;
  logic               arb_any_s;
  logic [PTR_W-1:0]   rr_next_s;
  logic               grant_ok_s;
  logic               drop_mode_s;
  logic               hb_grant_s;
  logic               src_grant_s;
  logic               hb_expire_s;
  logic [NUM_SRC-1:0] drop_mask_s;
  logic [4:0]         drop_inc_s;
  logic [DROP_W+4:0]  drop_sum_s;
  logic [DROP_W-1:0]  drop_sat_s;
  logic [15:0]        drop16_s;
  logic [NUM_SRC-1:0] src_ready_s;

  rr_arbiter #(.N(NUM_SRC), .IDX_W(PTR_W)) u_rr_arbiter (
    .req     (bus.src_valid),
    .ptr     (rr_ptr_r),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .any     (arb_any_s)
  );

  assign grant_ok_s  = enable & ~bus.fifo_almost_full;
  assign drop_mode_s = enable & bus.fifo_almost_full;
  // A pending heartbeat owns the slot ahead of every producer.
  assign hb_grant_s  = grant_ok_s & hb_pend_r;
  assign src_grant_s = grant_ok_s & ~hb_pend_r & arb_any_s;
  assign hb_expire_s = (HB_PERIOD != 0) && enable && (hb_cnt_r == 32'(HB_PERIOD - 1));
  assign rr_next_s   = (arb_idx_s == PTR_W'(NUM_SRC - 1)) ? '0 : arb_idx_s + PTR_W'(1);

  assign drop_mask_s = bus.src_valid & LOSSY_MASK;
  assign drop_inc_s  = 5'($countones(drop_mask_s));
  assign drop_sum_s  = (DROP_W + 5)'(drop_count_r) + (DROP_W + 5)'(drop_inc_s);
  assign drop_sat_s  = (drop_sum_s > DROP_MAX) ? '1 : drop_sum_s[DROP_W-1:0];
  // Heartbeat carries the low 16 bits of the drop counter, zero-extended if narrower.
  assign drop16_s    = 16'(drop_count_r);

  // Ready: the granted producer, or every valid lossy producer while throttled; forced low in reset.
  always_comb begin
    src_ready_s = '0;
    if (!rst_n) begin
      src_ready_s = '0;
    end else if (src_grant_s) begin
      src_ready_s = arb_gnt_s;
    end else if (drop_mode_s) begin
      src_ready_s = drop_mask_s;
    end else begin
      src_ready_s = '0;
    end
  end

  // Output register and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en_r <= 1'b0;
      fifo_data_r  <= '0;
      rr_ptr_r     <= '0;
    end else begin
      fifo_wr_en_r <= hb_grant_s | src_grant_s;
      if (hb_grant_s) begin
        fifo_data_r <= make_word(TAG_HEARTBEAT, {hb_seq_r, drop16_s});
      end else if (src_grant_s) begin
        fifo_data_r <= make_word(TAG_W'(arb_idx_s),
                                 bus.src_data[PAYLOAD_W*arb_idx_s +: PAYLOAD_W]);
      end else begin
        fifo_data_r <= fifo_data_r;
      end
      if (src_grant_s) begin
        rr_ptr_r <= rr_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Heartbeat timer: expiry sets pending even in the cycle the previous heartbeat is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_r  <= 32'd0;
      hb_pend_r <= 1'b0;
      hb_seq_r  <= 12'd0;
    end else begin
      if (hb_expire_s) begin
        hb_cnt_r  <= 32'd0;
        hb_pend_r <= 1'b1;
      end else begin
        if (enable && (HB_PERIOD != 0)) begin
          hb_cnt_r <= hb_cnt_r + 32'd1;
        end else begin
          hb_cnt_r <= hb_cnt_r;
        end
        if (hb_grant_s) begin
          hb_pend_r <= 1'b0;
        end else begin
          hb_pend_r <= hb_pend_r;
        end
      end
      if (hb_grant_s) begin
        hb_seq_r <= hb_seq_r + 12'd1;
      end else begin
        hb_seq_r <= hb_seq_r;
      end
    end
  end

  // Saturating drop counter for lossy words discarded under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_r <= '0;
    end else if (drop_mode_s) begin
      drop_count_r <= drop_sat_s;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  // Sticky overflow flag: a registered write landed on a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err_r <= 1'b0;
    end else if (fifo_wr_en_r && bus.fifo_full) begin
      overflow_err_r <= 1'b1;
    end else begin
      overflow_err_r <= overflow_err_r;
    end
  end

  assign bus.src_ready  = src_ready_s;
  assign bus.fifo_wr_en = fifo_wr_en_r;
  assign bus.fifo_data  = fifo_data_r;
  assign drop_count     = drop_count_r;
  assign overflow_err   = overflow_err_r;

endmodule

// File: tb/tb_esp32_stream_scheduler.sv
// Directed self-checking bench for esp32_stream_scheduler.
// dut_a: heartbeat off, 16-bit drop counter (arbitration, drops, overflow, enable, reset).
// dut_b: HB_PERIOD=8, 4-bit drop counter (heartbeat timing, priority, saturation).
module tb_esp32_stream_scheduler;
  import esp32_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_a;
  logic        enable_b;
  logic [15:0] drop_count_a;
  logic [3:0]  drop_count_b;
  logic        overflow_err_a;
  logic        overflow_err_b;
  logic [27:0] pay [3];
  logic [2:0]  exp_rdy;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  esp32_stream_scheduler_if #(.NUM_SRC(3)) bus_a ();
  esp32_stream_scheduler_if #(.NUM_SRC(3)) bus_b ();

  esp32_stream_scheduler #(
    .NUM_SRC(3), .LOSSY_MASK(3'b001), .HB_PERIOD(0), .DROP_W(16)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable_a),
    .bus          (bus_a),
    .drop_count   (drop_count_a),
    .overflow_err (overflow_err_a)
  );

  esp32_stream_scheduler #(
    .NUM_SRC(3), .LOSSY_MASK(3'b001), .HB_PERIOD(8), .DROP_W(4)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable_b),
    .bus          (bus_b),
    .drop_count   (drop_count_b),
    .overflow_err (overflow_err_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] src_word(input int idx);
    return {4'(idx), pay[idx]};
  endfunction

  initial begin
    pay[0] = 28'hA00_0001;
    pay[1] = 28'hB00_0002;
    pay[2] = 28'hC00_0003;
    rst_n    = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b0;
    bus_a.src_valid        = 3'b111;
    bus_a.src_data         = {pay[2], pay[1], pay[0]};
    bus_a.fifo_almost_full = 1'b0;
    bus_a.fifo_full        = 1'b0;
    bus_b.src_valid        = 3'b000;
    bus_b.src_data         = {pay[2], pay[1], pay[0]};
    bus_b.fifo_almost_full = 1'b0;
    bus_b.fifo_full        = 1'b0;

    // Reset state, with sources valid and enable high.
    #12;
    check_eq("rst_ready", bus_a.src_ready, 3'b000);
    check_eq("rst_wr_en", bus_a.fifo_wr_en, 1'b0);
    check_eq("rst_data", bus_a.fifo_data, 32'h0);
    check_eq("rst_drop", drop_count_a, 16'h0);
    check_eq("rst_ovf", overflow_err_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three sources valid, rotation 0,1,2,... with one-cycle write latency.
    for (int i = 0; i < 9; i++) begin
      #1;
      exp_rdy = 3'(1 << (i % 3));
      check_eq("rr_ready", bus_a.src_ready, exp_rdy);
      step();
      check_eq("rr_wr_en", bus_a.fifo_wr_en, 1'b1);
      check_eq("rr_data", bus_a.fifo_data, src_word(i % 3));
    end
    bus_a.src_valid = 3'b000;
    step();
    check_eq("idle_wr_en", bus_a.fifo_wr_en, 1'b0);
    check_eq("idle_data_hold", bus_a.fifo_data, src_word(2));

    // 2: almost full, lossy src0 dropped every cycle, src1 stalled.
    bus_a.fifo_almost_full = 1'b1;
    bus_a.src_valid        = 3'b011;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("drop_ready", bus_a.src_ready, 3'b001);
      step();
      check_eq("drop_wr_en", bus_a.fifo_wr_en, 1'b0);
    end
    check_eq("drop_count10", drop_count_a, 16'd10);
    bus_a.fifo_almost_full = 1'b0;
    bus_a.src_valid        = 3'b000;

    // 5: write while FIFO full -> sticky overflow.
    bus_a.src_valid = 3'b010;
    #1;
    check_eq("ovf_ready", bus_a.src_ready, 3'b010);
    step();
    check_eq("ovf_data", bus_a.fifo_data, src_word(1));
    bus_a.src_valid = 3'b000;
    bus_a.fifo_full = 1'b1;
    check_eq("ovf_before", overflow_err_a, 1'b0);
    step();
    bus_a.fifo_full = 1'b0;
    check_eq("ovf_set", overflow_err_a, 1'b1);
    step();
    step();
    check_eq("ovf_sticky", overflow_err_a, 1'b1);

    // 5: enable low blocks grants; arbitration resumes from rr_ptr=2.
    enable_a        = 1'b0;
    bus_a.src_valid = 3'b111;
    #1;
    check_eq("dis_ready", bus_a.src_ready, 3'b000);
    step();
    check_eq("dis_wr_en", bus_a.fifo_wr_en, 1'b0);
    enable_a = 1'b1;
    #1;
    check_eq("resume_ready", bus_a.src_ready, 3'b100);
    step();
    check_eq("resume_data", bus_a.fifo_data, src_word(2));
    #1;
    check_eq("resume_ready2", bus_a.src_ready, 3'b001);
    step();
    check_eq("resume_data2", bus_a.fifo_data, src_word(0));

    // 6: asynchronous reset mid-burst.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_wr_en", bus_a.fifo_wr_en, 1'b0);
    check_eq("arst_data", bus_a.fifo_data, 32'h0);
    check_eq("arst_drop", drop_count_a, 16'h0);
    check_eq("arst_ovf", overflow_err_a, 1'b0);
    check_eq("arst_ready", bus_a.src_ready, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready", bus_a.src_ready, 3'b001);
    step();
    check_eq("rel_data", bus_a.fifo_data, src_word(0));
    check_eq("rel_wr_en", bus_a.fifo_wr_en, 1'b1);
    enable_a        = 1'b0;
    bus_a.src_valid = 3'b000;

    // 3: heartbeat every 8 cycles on dut_b.
    enable_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq("hb_gap0", bus_b.fifo_wr_en, 1'b0);
    end
    step();
    check_eq("hb0_wr_en", bus_b.fifo_wr_en, 1'b1);
    check_eq("hb0_data", bus_b.fifo_data, 32'hF000_0000);
    for (int k = 10; k <= 16; k++) begin
      step();
      check_eq("hb_gap1", bus_b.fifo_wr_en, 1'b0);
    end
    step();
    check_eq("hb1_data", bus_b.fifo_data, 32'hF001_0000);

    // 3: expiry under almost full waits for the throttle to lift.
    bus_b.fifo_almost_full = 1'b1;
    for (int k = 18; k <= 26; k++) begin
      step();
      check_eq("hb_held", bus_b.fifo_wr_en, 1'b0);
    end
    bus_b.fifo_almost_full = 1'b0;
    step();
    check_eq("hb2_wr_en", bus_b.fifo_wr_en, 1'b1);
    check_eq("hb2_data", bus_b.fifo_data, 32'hF002_0000);

    // 4: heartbeat pending and src1 valid: heartbeat first, src1 next.
    for (int k = 28; k <= 32; k++) begin
      step();
      check_eq("hb_gap3", bus_b.fifo_wr_en, 1'b0);
    end
    bus_b.src_valid = 3'b010;
    #1;
    check_eq("hb_prio_ready", bus_b.src_ready, 3'b000);
    step();
    check_eq("hb3_data", bus_b.fifo_data, 32'hF003_0000);
    check_eq("after_hb_ready", bus_b.src_ready, 3'b010);
    step();
    check_eq("after_hb_data", bus_b.fifo_data, src_word(1));

    // 4: 4-bit drop counter saturates; heartbeat reports it zero-extended.
    bus_b.fifo_almost_full = 1'b1;
    bus_b.src_valid        = 3'b001;
    #1;
    check_eq("sat_ready", bus_b.src_ready, 3'b001);
    repeat (14) step();
    check_eq("drop14", drop_count_b, 4'hE);
    repeat (6) step();
    check_eq("drop_sat", drop_count_b, 4'hF);
    bus_b.fifo_almost_full = 1'b0;
    bus_b.src_valid        = 3'b000;
    step();
    check_eq("hb4_wr_en", bus_b.fifo_wr_en, 1'b1);
    check_eq("hb4_data", bus_b.fifo_data, 32'hF004_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
